// File: rtl/fp_div_pkg.sv
// ============================================================================
// Module      : fp_div_pkg
// Description : Shared constants and FSM state type for the FP divider
//               post-divide stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_div_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [EXP_W+MANT_W:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [EXP_W+MANT_W-1:0] INF = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};

endpackage

`default_nettype wire

// File: rtl/fp_round_inc.sv
// ============================================================================
// Module      : fp_round_inc
// Description : Combinational mantissa incrementer with carry-out. Rounds to
//               nearest-even when FP_DIV_RNE_ROUND_EN is defined, otherwise
//               truncates (round toward zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_inc #(
    parameter int MANT_W = 23
) (
    input  logic [MANT_W-1:0] mantIn,
    input  logic              guardBit,
    input  logic              stickyBit,
    input  logic              lsbBit,
    output logic [MANT_W-1:0] mantOut,
    output logic              carryOut
);

    logic wIncrement;

`ifdef FP_DIV_RNE_ROUND_EN
    assign wIncrement = guardBit & (stickyBit | lsbBit);
`else
    // Truncation never increments; the round bits only feed the inexact flag upstream.
    logic unusedRtzInputs;
    assign unusedRtzInputs = guardBit ^ stickyBit ^ lsbBit;
    assign wIncrement      = 1'b0;
`endif

    assign {carryOut, mantOut} = {1'b0, mantIn} + {{MANT_W{1'b0}}, wIncrement};

endmodule

`default_nettype wire

// File: rtl/fp_div_normalize_round.sv
// ============================================================================
// Module      : fp_div_normalize_round
// Description : Post-divide normalize / round / range-check / pack stage with
//               valid-ready output. Rounding mode selected by macro
//               FP_DIV_RNE_ROUND_EN (defined: RNE, undefined: toward zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_normalize_round
    import fp_div_pkg::*;
#(
    parameter int EXP_W  = fp_div_pkg::EXP_W,
    parameter int MANT_W = fp_div_pkg::MANT_W,
    parameter int Q_W    = MANT_W + 3,
    parameter int BIAS   = fp_div_pkg::BIAS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Q_W-1:0]          q_in,
    input  logic                    rem_nz,
    input  logic [EXP_W+1:0]        exp_in,
    input  logic                    sign_in,
    input  logic                    sp_nan,
    input  logic                    sp_inf,
    input  logic                    sp_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    flag_ovf,
    output logic                    flag_unf,
    output logic                    flag_inx
);

    localparam int RES_W = 1 + EXP_W + MANT_W;
    // All-ones biased exponent; for IEEE formats 2^EXP_W-1 == 2*BIAS+1.
    localparam logic [EXP_W+1:0] C_EXP_INF = (EXP_W+2)'(2 * BIAS + 1);
    localparam logic [RES_W-1:0] C_QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [EXP_W+1:0] C_ONE     = (EXP_W+2)'(1);

    state_e rState;
    state_e wNextState;

    logic [Q_W-1:0]    rQ;
    logic              rRemNz;
    logic [EXP_W+1:0]  rExpIn;
    logic              rSign;
    logic              rSpNan;
    logic              rSpInf;
    logic              rSpZero;

    logic [MANT_W-1:0] rMant;
    logic              rGuard;
    logic              rSticky;
    logic [EXP_W+1:0]  rExpNorm;

    logic              wCapture;
    logic [MANT_W-1:0] wMantNorm;
    logic              wGuardNorm;
    logic              wStickyNorm;
    logic [EXP_W+1:0]  wExpNorm;
    logic [MANT_W-1:0] wMantRnd;
    logic              wCarry;
    logic [EXP_W+1:0]  wExpRnd;
    logic [RES_W-1:0]  wPacked;
    logic              wOvf;
    logic              wUnf;
    logic              wInx;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rState <= IDLE;
        else       rState <= wNextState;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        wNextState = rState;
        case (rState)
            IDLE:    if (in_valid)  wNextState = NORM;
            NORM:                   wNextState = ROUND;
            ROUND:                  wNextState = DONE;
            DONE:    if (out_ready) wNextState = IDLE;
            default:                wNextState = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (rState)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign wCapture = (rState == IDLE) && in_valid;

    // Divider guarantees q[Q_W-2]=1 whenever q[Q_W-1]=0, so one shift is enough.
    always_comb begin
        if (rQ[Q_W-1]) begin
            wMantNorm   = rQ[Q_W-2:2];
            wGuardNorm  = rQ[1];
            wStickyNorm = rQ[0] | rRemNz;
            wExpNorm    = rExpIn;
        end else begin
            wMantNorm   = rQ[Q_W-3:1];
            wGuardNorm  = rQ[0];
            wStickyNorm = rRemNz;
            wExpNorm    = rExpIn - C_ONE;
        end
    end

    fp_round_inc #(
        .MANT_W (MANT_W)
    ) u_roundInc (
        .mantIn    (rMant),
        .guardBit  (rGuard),
        .stickyBit (rSticky),
        .lsbBit    (rMant[0]),
        .mantOut   (wMantRnd),
        .carryOut  (wCarry)
    );

    // Carry-out leaves the mantissa at zero, so only the exponent needs the bump.
    assign wExpRnd = rExpNorm + {{(EXP_W+1){1'b0}}, wCarry};

    always_comb begin
        wPacked = {rSign, wExpRnd[EXP_W-1:0], wMantRnd};
        wOvf    = 1'b0;
        wUnf    = 1'b0;
        wInx    = rGuard | rSticky;
        if (rSpNan) begin
            wPacked = C_QNAN;
            wInx    = 1'b0;
        end else if (rSpInf) begin
            wPacked = {rSign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            wInx    = 1'b0;
        end else if (rSpZero) begin
            wPacked = {rSign, {(EXP_W+MANT_W){1'b0}}};
            wInx    = 1'b0;
        end else if (wExpRnd[EXP_W+1] || (wExpRnd == '0)) begin
            // Negative or zero biased exponent: flush to signed zero.
            wPacked = {rSign, {(EXP_W+MANT_W){1'b0}}};
            wUnf    = 1'b1;
            wInx    = 1'b1;
        end else if (wExpRnd >= C_EXP_INF) begin
            wPacked = {rSign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            wOvf    = 1'b1;
            wInx    = 1'b1;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rQ       <= '0;
            rRemNz   <= 1'b0;
            rExpIn   <= '0;
            rSign    <= 1'b0;
            rSpNan   <= 1'b0;
            rSpInf   <= 1'b0;
            rSpZero  <= 1'b0;
            rMant    <= '0;
            rGuard   <= 1'b0;
            rSticky  <= 1'b0;
            rExpNorm <= '0;
            result   <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
        end else begin
            if (wCapture) begin
                rQ      <= q_in;
                rRemNz  <= rem_nz;
                rExpIn  <= exp_in;
                rSign   <= sign_in;
                rSpNan  <= sp_nan;
                rSpInf  <= sp_inf;
                rSpZero <= sp_zero;
            end
            if (rState == NORM) begin
                rMant    <= wMantNorm;
                rGuard   <= wGuardNorm;
                rSticky  <= wStickyNorm;
                rExpNorm <= wExpNorm;
            end
            if (rState == ROUND) begin
                result   <= wPacked;
                flag_ovf <= wOvf;
                flag_unf <= wUnf;
                flag_inx <= wInx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_div_normalize_round.sv
// ============================================================================
// Module      : tb_fp_div_normalize_round
// Description : Directed self-checking bench for fp_div_normalize_round;
//               expectations follow FP_DIV_RNE_ROUND_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_div_normalize_round;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] q_in;
    logic        rem_nz;
    logic [9:0]  exp_in;
    logic        sign_in;
    logic        sp_nan;
    logic        sp_inf;
    logic        sp_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [25:0] q;
        logic        rem;
        logic [9:0]  e;
        logic        s;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [31:0] res;
        logic [2:0]  flags;   // {ovf, unf, inx}
    } vec_t;

    vec_t vecs[$];

    fp_div_normalize_round dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .rem_nz    (rem_nz),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .sp_nan    (sp_nan),
        .sp_inf    (sp_inf),
        .sp_zero   (sp_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveOp(input vec_t v);
        q_in     = v.q;
        rem_nz   = v.rem;
        exp_in   = v.e;
        sign_in  = v.s;
        sp_nan   = v.nan;
        sp_inf   = v.inf;
        sp_zero  = v.zero;
        in_valid = 1'b1;
    endtask

    // Waits (bounded) for out_valid after the capture edge; returns edges elapsed.
    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic runOp(input vec_t v);
        int lat;
        @(negedge clock);
        driveOp(v);
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        waitValid(lat);
        // Capture edge counts as the first; out_valid rises two edges later.
        checkVal({v.tag, "/latency"}, lat, 2);
        checkVal({v.tag, "/result"}, result, v.res);
        checkVal({v.tag, "/flags"}, {29'd0, flag_ovf, flag_unf, flag_inx}, {29'd0, v.flags});
        @(posedge clock); #1;
        checkVal({v.tag, "/idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   lat;

        vecs.push_back('{"six_thirds", 26'h2000000, 1'b0, 10'd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000});
`ifdef FP_DIV_RNE_ROUND_EN
        // 1/3 presented as 0.666.. with exponent one lower.
        vecs.push_back('{"one_third", 26'h1555555, 1'b1, 10'd126, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3EAAAAAB, 3'b001});
        vecs.push_back('{"round_carry", 26'h3FFFFFF, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001});
        vecs.push_back('{"tie_odd", 26'h2000006, 1'b0, 10'd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000002, 3'b001});
        vecs.push_back('{"carry_ovf", 26'h3FFFFFF, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101});
`else
        vecs.push_back('{"one_third", 26'h1555555, 1'b1, 10'd126, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3EAAAAAA, 3'b001});
        vecs.push_back('{"round_carry", 26'h3FFFFFF, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3FFFFFFF, 3'b001});
        vecs.push_back('{"tie_odd", 26'h2000006, 1'b0, 10'd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000001, 3'b001});
        vecs.push_back('{"carry_ovf", 26'h3FFFFFF, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b001});
`endif
        vecs.push_back('{"tie_even", 26'h2000002, 1'b0, 10'd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001});
        vecs.push_back('{"ovf", 26'h2000000, 1'b0, 10'd255, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101});
        vecs.push_back('{"ovf_neg", 26'h2000000, 1'b0, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF800000, 3'b101});
        vecs.push_back('{"max_norm", 26'h2000000, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F000000, 3'b000});
        vecs.push_back('{"unf", 26'h1000000, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b011});
        vecs.push_back('{"min_norm", 26'h1000000, 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00800000, 3'b000});
        vecs.push_back('{"neg_exp", 26'h2000000, 1'b0, 10'h3FB, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011});
        vecs.push_back('{"neg_one", 26'h2000000, 1'b0, 10'd127, 1'b1, 1'b0, 1'b0, 1'b0, 32'hBF800000, 3'b000});
        vecs.push_back('{"nan_inf", 26'h3FFFFFF, 1'b1, 10'd300, 1'b1, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 3'b000});
        vecs.push_back('{"inf_neg", 26'h2000000, 1'b0, 10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFF800000, 3'b000});
        vecs.push_back('{"zero_neg", 26'h3FFFFFF, 1'b1, 10'd300, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000000, 3'b000});

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_in      = '0;
        rem_nz    = 1'b0;
        exp_in    = '0;
        sign_in   = 1'b0;
        sp_nan    = 1'b0;
        sp_inf    = 1'b0;
        sp_zero   = 1'b0;
        #12;
        checkVal("reset/result", result, 32'h0);
        checkVal("reset/ctrl", {26'd0, in_ready, out_valid, 1'b0, flag_ovf, flag_unf, flag_inx}, 32'h20);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) runOp(vecs[i]);

        // Output held stable while the consumer stalls.
        v = vecs[0];
        @(negedge clock);
        driveOp(v);
        out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        waitValid(lat);
        checkVal("hold/latency", lat, 2);
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            checkVal("hold/result", result, 32'h40000000);
            checkVal("hold/valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        checkVal("hold/release", {30'd0, in_ready, out_valid}, 32'd2);

        // A new request arriving while busy must not be taken.
        v = vecs[0];
        @(negedge clock);
        driveOp(v);
        @(posedge clock); #1;
        v = vecs[12];
        driveOp(v);
        checkVal("busy/in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        checkVal("busy/result", result, 32'h40000000);
        checkVal("busy/valid", {31'd0, out_valid}, 32'd1);
        @(posedge clock); #1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            checkVal("busy/no_second", {30'd0, in_ready, out_valid}, 32'd2);
        end

        // Reset mid-operation discards the operation immediately.
        v = vecs[1];
        @(negedge clock);
        driveOp(v);
        @(posedge clock); #1;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkVal("rst_norm/ctrl", {30'd0, in_ready, out_valid}, 32'd2);
        checkVal("rst_norm/result", result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            checkVal("rst_norm/discard", {30'd0, in_ready, out_valid}, 32'd2);
        end

        // Stage still works after the mid-flight reset.
        runOp(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
